// File: rtl/uart_echo_pkg.sv
// ---------------------------------------------------------------------------
// uart_echo_pkg
//   Shared types and default parameters for the UART echo controller.
//   - rx_state_t : receive-side FSM states (pop bytes out of the UART core)
//   - tx_state_t : transmit-side FSM states (write bytes back into the core)
//   - DEF_*      : default parameter values used by the top level
// ---------------------------------------------------------------------------
package uart_echo_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_GUARD_CYCLES = 2;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_READ = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WRITE = 2'd1,
    TX_GUARD = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_t;

endpackage : uart_echo_pkg

// File: rtl/echo_sync_fifo.sv
// ---------------------------------------------------------------------------
// echo_sync_fifo
//   Single-clock show-ahead FIFO used as the echo buffer.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push, din       : write request and data
//     pop             : read request (consumes the current head)
//     dout            : current head entry (valid whenever !empty)
//     full, empty     : occupancy flags
//     count           : entries currently stored (0..FIFO_DEPTH)
//   A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
//   when a pop happens in the same cycle; otherwise it is ignored.
// ---------------------------------------------------------------------------
module echo_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  assign w_do_pop  = pop & ~w_empty;
  // On a full FIFO the slot being written is the one the head leaves on this
  // same edge, so push+pop is safe.
  assign w_do_push = push & (~w_full | w_do_pop);

  // Storage is not reset: occupancy is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule : echo_sync_fifo

// File: rtl/uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_echo_ctrl
//   Host-side controller for the CoreUART parallel interface. Every byte the
//   UART receives is read out (rxrdy/oen), buffered, and written back to the
//   UART transmitter (txrdy/wen), forming an echo path. Receive and transmit
//   are independent FSMs so reception never waits on transmission.
//
//   Handshakes: the UART raises uart_rxrdy while a byte is on uart_data_out;
//   we answer with exactly one low cycle of uart_oen, capturing the byte at
//   the end of that cycle, then wait for uart_rxrdy to drop before looking
//   again. We start a write only when uart_txrdy is high, drive uart_wen low
//   for exactly one cycle with uart_data_in valid, ignore uart_txrdy for
//   GUARD_CYCLES cycles, then wait for uart_txrdy before the next write.
//
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     uart_rxrdy          : UART has a received byte
//     uart_data_out       : received byte from UART
//     uart_oen            : active-low read strobe to UART (registered)
//     uart_txrdy          : UART transmitter can accept a byte
//     uart_data_in        : byte to transmit (registered, held between writes)
//     uart_wen            : active-low write strobe to UART (registered)
//     echo_en             : allows new writes to start
//     fifo_count          : bytes currently buffered
//     overflow            : sticky, a received byte was dropped
//     clr_overflow        : synchronous clear of overflow (set wins)
//     dbg_rx_state        : current receive FSM state
//     dbg_tx_state        : current transmit FSM state
// ---------------------------------------------------------------------------
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_rxrdy,
  input  logic [DATA_W-1:0]           uart_data_out,
  output logic                        uart_oen,
  input  logic                        uart_txrdy,
  output logic [DATA_W-1:0]           uart_data_in,
  output logic                        uart_wen,
  input  logic                        echo_en,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output rx_state_t                   dbg_rx_state,
  output tx_state_t                   dbg_tx_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  // FSM state
  rx_state_t r_rx_state;
  rx_state_t w_rx_next;
  tx_state_t r_tx_state;
  tx_state_t w_tx_next;

  // Registered outputs and internal registers
  logic              r_oen;
  logic              r_wen;
  logic [DATA_W-1:0] r_data_in;
  logic [GW-1:0]     r_guard_cnt;
  logic              r_overflow;

  // Next-value wires for the registered outputs
  logic w_oen_d;
  logic w_wen_d;
  logic w_load_data;

  // FIFO interface
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_dout;
  logic [CW-1:0]     w_fifo_count;

  logic w_drop;
  logic w_guard_done;

  // The byte is captured on the edge that ends the read-strobe cycle, and
  // the head is consumed on the edge that ends the write-strobe cycle.
  assign w_push = (r_rx_state == RX_READ);
  assign w_pop  = (r_tx_state == TX_WRITE);

  // The UART is drained even when the buffer is full; such a byte is lost.
  assign w_drop = w_push & w_fifo_full & ~w_pop;

  assign w_guard_done = (r_guard_cnt == '0);

  echo_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (uart_data_out),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // ------------------------------------------------------------------------
  // Receive FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: if (uart_rxrdy)  w_rx_next = RX_READ;
      RX_READ:                  w_rx_next = RX_WAIT;
      // rxrdy may lag the strobe; wait for it to fall so one byte is never
      // read twice.
      RX_WAIT: if (!uart_rxrdy) w_rx_next = RX_IDLE;
      default:                  w_rx_next = RX_IDLE;
    endcase
  end

  // Strobe is decoded from the next state and then registered, so it is
  // low exactly while the FSM sits in RX_READ.
  always_comb begin
    w_oen_d = (w_rx_next != RX_READ);
  end

  // ------------------------------------------------------------------------
  // Transmit FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (echo_en && !w_fifo_empty && uart_txrdy) w_tx_next = TX_WRITE;
      TX_WRITE:                                            w_tx_next = TX_GUARD;
      // txrdy is not looked at here: the UART may take a cycle or two to
      // drop it after the strobe.
      TX_GUARD: if (w_guard_done)                          w_tx_next = TX_WAIT;
      TX_WAIT:  if (uart_txrdy)                            w_tx_next = TX_IDLE;
      default:                                             w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_wen_d     = (w_tx_next != TX_WRITE);
    w_load_data = (r_tx_state == TX_IDLE) && (w_tx_next == TX_WRITE);
  end

  // Guard counter: loaded during the write cycle so TX_GUARD lasts exactly
  // GUARD_CYCLES cycles (counts GUARD_CYCLES-1 down to 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guard_cnt <= '0;
    end else if (r_tx_state == TX_WRITE) begin
      r_guard_cnt <= GW'(GUARD_CYCLES - 1);
    end else if ((r_tx_state == TX_GUARD) && !w_guard_done) begin
      r_guard_cnt <= r_guard_cnt - GW'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oen     <= 1'b1;
      r_wen     <= 1'b1;
      r_data_in <= '0;
    end else begin
      r_oen <= w_oen_d;
      r_wen <= w_wen_d;
      // Data is taken from the show-ahead head on entry to TX_WRITE and held
      // until the next write starts.
      if (w_load_data) begin
        r_data_in <= w_fifo_dout;
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign uart_oen     = r_oen;
  assign uart_wen     = r_wen;
  assign uart_data_in = r_data_in;
  assign fifo_count   = w_fifo_count;
  assign overflow     = r_overflow;
  assign dbg_rx_state = r_rx_state;
  assign dbg_tx_state = r_tx_state;

endmodule : uart_echo_ctrl

// File: tb/tb_uart_echo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_ctrl
//   Directed bench for uart_echo_ctrl. A small UART stub drives the receive
//   and transmit handshakes; a queue-based model of the echo buffer predicts
//   fifo_count, overflow and the byte carried by each write strobe, and is
//   compared against the DUT on every falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_echo_ctrl;
  import uart_echo_pkg::*;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int GUARD_CYCLES = 2;
  localparam int CW           = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              uart_rxrdy;
  logic [DATA_W-1:0] uart_data_out;
  logic              uart_oen;
  logic              uart_txrdy;
  logic [DATA_W-1:0] uart_data_in;
  logic              uart_wen;
  logic              echo_en;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic              clr_overflow;
  rx_state_t         dbg_rx_state;
  tx_state_t         dbg_tx_state;

  uart_echo_ctrl #(
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxrdy    (uart_rxrdy),
    .uart_data_out (uart_data_out),
    .uart_oen      (uart_oen),
    .uart_txrdy    (uart_txrdy),
    .uart_data_in  (uart_data_in),
    .uart_wen      (uart_wen),
    .echo_en       (echo_en),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .dbg_rx_state  (dbg_rx_state),
    .dbg_tx_state  (dbg_tx_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];     // bytes the model holds, oldest first
  logic [DATA_W-1:0] emit_log[$];  // bytes seen on write strobes
  int                wen_cyc_log[$];
  logic              m_ov   = 1'b0;
  logic [DATA_W-1:0] m_last = '0;  // value uart_data_in must hold
  bit                m_drop;
  int                wen_pulses   = 0;
  int                oen_pulses   = 0;
  int                cyc          = 0;
  int                last_wen_cyc = -1000;
  int                peak_count   = 0;
  int                tx_hold      = 0;
  logic prev_txrdy = 1'b1;
  logic prev_en    = 1'b0;
  logic prev_oen   = 1'b1;
  logic prev_wen   = 1'b1;
  logic prev_rxrdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_oen",      32'(uart_oen),      32'(1));
      chk("rst_wen",      32'(uart_wen),      32'(1));
      chk("rst_data_in",  32'(uart_data_in),  32'(0));
      chk("rst_count",    32'(fifo_count),    32'(0));
      chk("rst_overflow", 32'(overflow),      32'(0));
      chk("rst_rx_state", 32'(dbg_rx_state),  32'(RX_IDLE));
      chk("rst_tx_state", 32'(dbg_tx_state),  32'(TX_IDLE));
      exp_q.delete();
      m_ov         = 1'b0;
      m_last       = '0;
      last_wen_cyc = -1000;
    end else begin
      chk("model_count",    32'(fifo_count), 32'(exp_q.size()));
      chk("model_overflow", 32'(overflow),   32'(m_ov));
      if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);

      // Write strobe: must carry the oldest buffered byte.
      if (uart_wen == 1'b0) begin
        wen_pulses++;
        chk("wen_single_cycle",  32'(prev_wen),   32'(1));
        chk("wen_needs_txrdy",   32'(prev_txrdy), 32'(1));
        chk("wen_needs_echo_en", 32'(prev_en),    32'(1));
        chk("wen_spacing_ok", 32'(cyc - last_wen_cyc >= GUARD_CYCLES + 2), 32'(1));
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wen_unexpected: got data 0x%0h with nothing buffered (t=%0t)",
                   uart_data_in, $time);
        end else if (uart_data_in !== exp_q[0]) begin
          failures++;
          $display("FAIL wen_data: got 0x%0h expected 0x%0h (t=%0t)",
                   uart_data_in, exp_q[0], $time);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        emit_log.push_back(uart_data_in);
        wen_cyc_log.push_back(cyc);
        m_last       = uart_data_in;
        last_wen_cyc = cyc;
      end else begin
        chk("data_in_hold", 32'(uart_data_in), 32'(m_last));
      end

      // Read strobe: the stub's byte enters the buffer unless it is full.
      m_drop = 1'b0;
      if (uart_oen == 1'b0) begin
        oen_pulses++;
        chk("oen_single_cycle", 32'(prev_oen),   32'(1));
        chk("oen_needs_rxrdy",  32'(prev_rxrdy), 32'(1));
        if (exp_q.size() == FIFO_DEPTH) m_drop = 1'b1;
        else exp_q.push_back(uart_data_out);
      end
      if (m_drop)            m_ov = 1'b1;
      else if (clr_overflow) m_ov = 1'b0;
    end
    prev_txrdy = uart_txrdy;
    prev_en    = echo_en;
    prev_oen   = uart_oen;
    prev_wen   = uart_wen;
    prev_rxrdy = uart_rxrdy;
    cyc++;
  end

  // ---------------- UART transmit stub ----------------
  // After a write strobe, txrdy drops one cycle later for tx_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && uart_wen == 1'b0 && tx_hold > 0) begin
        @(posedge clk); #2;
        uart_txrdy = 1'b0;
        repeat (tx_hold) @(posedge clk);
        #2;
        uart_txrdy = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Present one byte on the receive side, wait for the read strobe, keep
  // rxrdy high for 'hold' further cycles, then release it.
  task automatic send_byte(input logic [DATA_W-1:0] b, input int hold, input bit clr_during);
    int start;
    bit got;
    start = oen_pulses;
    got   = 1'b0;
    uart_data_out = b;
    uart_rxrdy    = 1'b1;
    if (clr_during) clr_overflow = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (oen_pulses != start) got = 1'b1;
    end
    clr_overflow = 1'b0;
    repeat (hold) tick();
    uart_rxrdy = 1'b0;
    repeat (3) tick();
    chk("oen_pulses_per_byte", 32'(oen_pulses - start), 32'(1));
  endtask

  task automatic wait_wen(input int target, input int budget, input string name);
    for (int i = 0; i < budget && wen_pulses < target; i++) tick();
    repeat (2) tick();
    chk(name, 32'(wen_pulses), 32'(target));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int start;
    bit found;

    uart_rxrdy    = 1'b0;
    uart_data_out = '0;
    uart_txrdy    = 1'b1;
    echo_en       = 1'b0;
    clr_overflow  = 1'b0;
    rst_n         = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("init_oen",      32'(uart_oen),   32'(1));
    chk("init_wen",      32'(uart_wen),   32'(1));
    chk("init_count",    32'(fifo_count), 32'(0));
    chk("init_overflow", 32'(overflow),   32'(0));
    rst_n = 1'b1;
    tick();

    // Single echo
    echo_en    = 1'b1;
    tx_hold    = 3;
    peak_count = 0;
    base       = wen_pulses;
    send_byte(8'h8F, 0, 1'b0);
    wait_wen(base + 1, 30, "single_wen_count");
    repeat (6) tick();
    chk("single_data",  32'(uart_data_in), 32'h8F);
    chk("single_count", 32'(fifo_count),   32'(0));
    chk("single_peak",  32'(peak_count),   32'(1));

    // Slow rxrdy release: still one read strobe
    base = wen_pulses;
    send_byte(8'h3C, 5, 1'b0);
    wait_wen(base + 1, 30, "slow_wen_count");
    repeat (6) tick();
    chk("slow_data", 32'(uart_data_in), 32'h3C);

    // Back-pressure and overflow
    echo_en = 1'b0;
    tx_hold = 0;
    repeat (10) tick();
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 0, 1'b0);
    chk("bp_count_full", 32'(fifo_count), 32'(16));
    chk("bp_no_overflow", 32'(overflow),  32'(0));
    send_byte(8'h11, 0, 1'b0);
    chk("bp_overflow_set", 32'(overflow),   32'(1));
    chk("bp_count_held",   32'(fifo_count), 32'(16));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tick();
    chk("bp_overflow_clr", 32'(overflow), 32'(0));
    send_byte(8'h12, 0, 1'b1);
    chk("ov_set_beats_clr", 32'(overflow), 32'(1));
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tick();
    chk("ov_clr_again", 32'(overflow), 32'(0));
    emit_log.delete();
    base    = wen_pulses;
    echo_en = 1'b1;
    wait_wen(base + 16, 200, "bp_drain_count");
    chk("bp_drain_empty", 32'(fifo_count),      32'(0));
    chk("bp_emit_size",   32'(emit_log.size()), 32'(16));
    if (emit_log.size() == 16) begin
      chk("bp_first", 32'(emit_log[0]),  32'h01);
      chk("bp_last",  32'(emit_log[15]), 32'h10);
    end

    // Transmit pacing with a slow UART
    echo_en = 1'b0;
    tx_hold = 11;
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    emit_log.delete();
    wen_cyc_log.delete();
    base    = wen_pulses;
    echo_en = 1'b1;
    wait_wen(base + 1, 20, "pace_first_wen");
    repeat (5) tick();
    chk("pace_hold_a5", 32'(uart_data_in), 32'hA5);
    wait_wen(base + 2, 40, "pace_second_wen");
    if (emit_log.size() == 2 && wen_cyc_log.size() == 2) begin
      chk("pace_first",  32'(emit_log[0]), 32'hA5);
      chk("pace_second", 32'(emit_log[1]), 32'h5A);
      chk("pace_gap_ge_12", 32'(wen_cyc_log[1] - wen_cyc_log[0] >= 12), 32'(1));
    end else begin
      chk("pace_emit_size", 32'(emit_log.size()), 32'(2));
    end
    tx_hold = 0;
    repeat (15) tick();

    // Simultaneous push and pop on a full buffer
    echo_en = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 0, 1'b0);
    chk("sim_prefill", 32'(fifo_count), 32'(16));
    emit_log.delete();
    base          = wen_pulses;
    start         = oen_pulses;
    uart_data_out = 8'h77;
    uart_rxrdy    = 1'b1;
    echo_en       = 1'b1;
    tick();
    tick();
    chk("sim_count_16", 32'(fifo_count), 32'(16));
    chk("sim_no_ovf",   32'(overflow),   32'(0));
    uart_rxrdy = 1'b0;
    wait_wen(base + 17, 200, "sim_drain_count");
    chk("sim_one_read", 32'(oen_pulses - start), 32'(1));
    chk("sim_empty",    32'(fifo_count),         32'(0));
    if (emit_log.size() == 17) begin
      chk("sim_first", 32'(emit_log[0]),  32'h20);
      chk("sim_last",  32'(emit_log[16]), 32'h77);
    end else begin
      chk("sim_emit_size", 32'(emit_log.size()), 32'(17));
    end

    // Reset asserted during a write strobe
    echo_en = 1'b0;
    send_byte(8'h99, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    chk("rstw_count_2", 32'(fifo_count), 32'(2));
    echo_en = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_wen == 1'b0) found = 1'b1;
    end
    chk("rstw_found_write", 32'(found), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_async_wen",   32'(uart_wen),     32'(1));
    chk("rstw_async_oen",   32'(uart_oen),     32'(1));
    chk("rstw_async_count", 32'(fifo_count),   32'(0));
    chk("rstw_async_data",  32'(uart_data_in), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base  = wen_pulses;
    repeat (20) tick();
    chk("rstw_no_wen_after", 32'(wen_pulses), 32'(base));
    chk("rstw_count_0",      32'(fifo_count), 32'(0));

    // Recovery after reset
    send_byte(8'h42, 0, 1'b0);
    wait_wen(base + 1, 30, "recover_wen_count");
    chk("recover_data", 32'(uart_data_in), 32'h42);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_echo_ctrl

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
- Host-side controller for the CoreUART parallel interface, directly upstream/downstream of the UART core.
- Pops each received byte from the UART (rxrdy/oen handshake) and buffers it in a small FIFO.
- Writes buffered bytes back through the transmit side (txrdy/wen handshake); this forms the echo path of the Echo module.
- Receive and transmit run as independent FSMs so reception never stalls behind transmission.

Parameters:
- DATA_W, 8, UART character width.
- FIFO_DEPTH, 16, echo buffer entries; power of two, ≥2.
- GUARD_CYCLES, 2, cycles after a wen pulse during which uart_txrdy is ignored; ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- uart_rxrdy  input  1  UART has a received byte on uart_data_out
- uart_data_out  input  DATA_W  received byte from UART
- uart_oen  output  1  active-low read strobe to UART
- uart_txrdy  input  1  UART transmitter can accept a byte
- uart_data_in  output  DATA_W  byte to transmit
- uart_wen  output  1  active-low write strobe to UART
- echo_en  input  1  1 = transmit FSM may start new writes
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- overflow  output  1  sticky: a received byte was dropped
- clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values:
  - uart_oen=1, uart_wen=1, uart_data_in=0.
  - fifo_count=0, overflow=0.
  - Both FSMs in IDLE, FIFO empty.
- Reset asserted mid-operation aborts any strobe immediately: outputs return to reset values asynchronously and buffered bytes are lost.
- All outputs are registered.
- RX FSM:
  - RX_IDLE: uart_rxrdy=1 → RX_READ.
  - RX_READ: exactly one cycle with uart_oen=0. uart_data_out is captured on the edge ending this cycle and pushed. → RX_WAIT.
  - RX_WAIT: uart_oen=1; stay until uart_rxrdy=0, then → RX_IDLE. This prevents a double-read of one byte while the UART's rxrdy lags the strobe.
  - The UART is always drained, even when the FIFO is full.
  - Push when the FIFO is full and no pop occurs in the same cycle: byte dropped, overflow set.
  - Push with a simultaneous pop on a full FIFO: byte accepted, count unchanged.
- TX FSM:
  - TX_IDLE: echo_en=1 & FIFO non-empty & uart_txrdy=1 → TX_WRITE.
  - TX_WRITE: one cycle with uart_wen=0. uart_data_in = FIFO head, registered on entry and held stable until the next TX_WRITE. FIFO popped this cycle. → TX_GUARD.
  - TX_GUARD: uart_wen=1; uart_txrdy ignored for GUARD_CYCLES cycles, covering the UART's 1–2 cycle delay in dropping txrdy. → TX_WAIT.
  - TX_WAIT: stay until uart_txrdy=1, then → TX_IDLE.
  - Minimum spacing between wen strobes: GUARD_CYCLES+2 cycles.
  - echo_en=0 blocks only new starts; a write in progress completes.
- FIFO:
  - fifo_count updates on the edge after a push/pop.
  - Push and pop in the same cycle: count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Ordering is strictly FIFO.
- Latency:
  - uart_rxrdy rise → uart_oen low: 1 cycle.
  - Byte pushed → uart_wen low: ≥2 cycles (push edge, IDLE decision, WRITE).
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow=1 clears it on the next edge.

Decomposition:
- Package uart_echo_pkg holds:
  - rx_state_t (RX_IDLE, RX_READ, RX_WAIT).
  - tx_state_t (TX_IDLE, TX_WRITE, TX_GUARD, TX_WAIT).
  - Default DATA_W constant.
- Sub-module echo_sync_fifo (parameters DATA_W, FIFO_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout (show-ahead head), full, empty, count.
  - Pop when empty is ignored; push when full without a pop is ignored.
- Top level contains the two FSMs, guard counter and overflow flag.

Test Plan:
- Single echo: UART stub presents 0x8F with rxrdy=1 → one 1-cycle oen low pulse. Then after rxrdy falls, exactly one 1-cycle wen low pulse with uart_data_in=0x8F; fifo_count goes 0→1→0.
- Slow rxrdy release: stub holds rxrdy high 5 cycles after oen → still only one oen pulse and one byte pushed.
- Back-pressure: echo_en=0, stub sends 0x01..0x10 → fifo_count=16, overflow=0. A 17th byte (0x11) is still read (oen pulses) but dropped, overflow=1. Then echo_en=1 → wen pulses carry 0x01..0x10 in order, ending at fifo_count=0.
- TX pacing: stub holds txrdy low 11 cycles after each wen, FIFO preloaded with 0xA5, 0x5A → second wen pulse occurs only after txrdy returns high. No wen pulses while txrdy is low; data_in stays 0xA5 until the second TX_WRITE.
- Simultaneous: FIFO full (16 bytes) and pop coincides with a push of 0x77 → byte accepted, overflow stays 0, count stays 16, 0x77 emitted last.
- Reset mid-write: assert rst_n=0 during the TX_WRITE cycle → uart_wen=1, uart_oen=1, fifo_count=0 immediately without waiting for a clock edge. After release, no wen pulse until a new byte arrives.
